// File: rtl/jtag_drv_if.sv
// Command/response handshake bundle for the JTAG master.
// master = host side, slave = jtag_drv.
interface jtag_drv_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_len;
    logic [31:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;

    modport master (
        output cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/jtag_drv.sv
// Host-side JTAG master: TAP walks, IR/DR shifts of 1..32 bits, TCK = CLK/(2*DIV).
// Define JTAG_DRV_TRST_EN to pulse TRST low during the RESET op.
module jtag_drv #(
    parameter int DIV = 4
) (
    input  logic        CLK,
    input  logic        rst,
    jtag_drv_if.slave   bus,
    output logic        busy,
    output logic        TCK,
    output logic        TMS,
    output logic        TDI,
    input  logic        TDO,
    output logic        TRST
);

    typedef enum logic [2:0] {
        IDLE_WAIT,
        PRE,
        SHIFT,
        POST,
        RESP
    } st_e;

    localparam logic [1:0] OP_RESET = 2'd0;
    localparam logic [1:0] OP_IR    = 2'd1;
    localparam logic [1:0] OP_DR    = 2'd2;
    localparam logic [1:0] OP_IDLE  = 2'd3;

    st_e         st;
    logic [1:0]  op_q;
    logic [4:0]  len_q;
    logic [31:0] data_q;
    logic [4:0]  idx;
    logic [15:0] cnt;
    logic        rdy_q;
    logic        rv_q;
    logic [31:0] rd_q;
    logic [4:0]  last;
    logic [4:0]  nxt_idx;
    logic        tck_end;
    logic        shift_op;

    function automatic logic step_tms(
        input logic [1:0] op,
        input st_e        s,
        input logic [4:0] i,
        input logic [4:0] len
    );
        logic t;
        t = 1'b0;
        case (s)
            PRE: begin
                case (op)
                    OP_RESET: t = (i != 5'd5);
                    OP_IR:    t = (i < 5'd2);
                    OP_DR:    t = (i == 5'd0);
                    default:  t = 1'b0;
                endcase
            end
            SHIFT:   t = (op != OP_IDLE) && (i == len);
            POST:    t = (i == 5'd0);
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    assign bus.cmd_ready = rdy_q;
    assign bus.rsp_valid = rv_q;
    assign bus.rsp_data  = rd_q;

    assign nxt_idx  = idx + 5'd1;
    assign tck_end  = (cnt == 16'(DIV - 1));
    assign shift_op = (op_q == OP_IR) || (op_q == OP_DR);

    // Index of the final TCK step within the current phase
    always_comb begin
        last = 5'd1;
        case (st)
            PRE: begin
                case (op_q)
                    OP_RESET: last = 5'd5;
                    OP_IR:    last = 5'd3;
                    default:  last = 5'd2;
                endcase
            end
            SHIFT:   last = len_q;
            default: last = 5'd1;
        endcase
    end

`ifdef JTAG_DRV_TRST_EN
    logic trst_q;
    assign TRST = trst_q;
`else
    assign TRST = 1'b1;
`endif

    always_ff @(posedge CLK) begin
        if (!rst) begin
            st     <= IDLE_WAIT;
            op_q   <= '0;
            len_q  <= '0;
            data_q <= '0;
            idx    <= '0;
            cnt    <= '0;
            rdy_q  <= 1'b0;
            rv_q   <= 1'b0;
            rd_q   <= '0;
            busy   <= 1'b0;
            TCK    <= 1'b0;
            TMS    <= 1'b1;
            TDI    <= 1'b0;
`ifdef JTAG_DRV_TRST_EN
            trst_q <= 1'b1;
`endif
        end else begin
            unique case (st)
                IDLE_WAIT: begin
                    if (bus.cmd_valid && rdy_q) begin
                        op_q   <= bus.cmd_op;
                        len_q  <= bus.cmd_len;
                        data_q <= bus.cmd_data;
                        rdy_q  <= 1'b0;
                        busy   <= 1'b1;
                        cnt    <= '0;
                        idx    <= '0;
                        rd_q   <= '0;
                        TDI    <= 1'b0;
                        if (bus.cmd_op == OP_IDLE) begin
                            st  <= SHIFT;
                            TMS <= 1'b0;
                        end else begin
                            st  <= PRE;
                            TMS <= step_tms(bus.cmd_op, PRE, 5'd0, bus.cmd_len);
                        end
`ifdef JTAG_DRV_TRST_EN
                        trst_q <= (bus.cmd_op != OP_RESET);
`endif
                    end else begin
                        rdy_q <= 1'b1;
                    end
                end
                PRE, SHIFT, POST: begin
                    if (!tck_end) begin
                        cnt <= cnt + 16'd1;
                    end else begin
                        cnt <= '0;
                        if (!TCK) begin
                            TCK <= 1'b1;
                            if (st == SHIFT && shift_op) rd_q[idx] <= TDO;
                        end else begin
                            // Falling edge: present the next step's TMS/TDI
                            TCK <= 1'b0;
                            if (idx != last) begin
                                idx <= nxt_idx;
                                TMS <= step_tms(op_q, st, nxt_idx, len_q);
                                TDI <= (st == SHIFT) && shift_op && data_q[nxt_idx];
`ifdef JTAG_DRV_TRST_EN
                                if (st == PRE && idx == 5'd1) trst_q <= 1'b1;
`endif
                            end else begin
                                idx <= '0;
                                TDI <= 1'b0;
                                case (st)
                                    PRE: begin
                                        if (op_q == OP_RESET) begin
                                            st    <= IDLE_WAIT;
                                            busy  <= 1'b0;
                                            rdy_q <= 1'b1;
                                        end else begin
                                            st  <= SHIFT;
                                            TMS <= step_tms(op_q, SHIFT, 5'd0, len_q);
                                            TDI <= data_q[0];
                                        end
                                    end
                                    SHIFT: begin
                                        if (op_q == OP_IDLE) begin
                                            st    <= IDLE_WAIT;
                                            busy  <= 1'b0;
                                            rdy_q <= 1'b1;
                                        end else begin
                                            st  <= POST;
                                            TMS <= 1'b1;
                                        end
                                    end
                                    default: begin
                                        st   <= RESP;
                                        busy <= 1'b0;
                                        rv_q <= 1'b1;
                                    end
                                endcase
                            end
                        end
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rv_q  <= 1'b0;
                        rdy_q <= 1'b1;
                        st    <= IDLE_WAIT;
                    end
                end
                default: st <= IDLE_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_drv.sv
// Randomized scoreboard bench for jtag_drv: TCK-level TMS/TDI/TRST and
// response checking against a TAP-walk reference model.
module tb_jtag_drv;
    localparam int DIV = 2;

    logic CLK = 1'b0;
    logic rst = 1'b0;
    logic busy, TCK, TMS, TDI, TDO, TRST;

    jtag_drv_if bus ();

    jtag_drv #(.DIV(DIV)) dut (
        .CLK  (CLK),
        .rst  (rst),
        .bus  (bus),
        .busy (busy),
        .TCK  (TCK),
        .TMS  (TMS),
        .TDI  (TDI),
        .TDO  (TDO),
        .TRST (TRST)
    );

    always #5 CLK = ~CLK;

    int n_pass = 0;
    int n_chk  = 0;

    bit          tdo_bits [8192];
    int          tck_n     = 0;
    logic        loop_ff   = 1'b0;
    bit          loop_mode = 1'b0;
    bit          hold      = 1'b0;
    int          model_tck = 0;
    bit          exp_tms  [$];
    bit          exp_tdi  [$];
    bit          exp_trst [$];
    logic [31:0] exp_rsp  [$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Scan-core stand-in: random TDO per TCK cycle, or TDI looped via one TCK flop
    assign TDO = loop_mode ? loop_ff : tdo_bits[tck_n];

    always @(posedge TCK) begin
        if (exp_tms.size() == 0) begin
            n_chk++;
            $display("FAIL tck_extra: unexpected TCK rise at %0t", $time);
        end else begin
            chk("tms", 32'(TMS), 32'(exp_tms.pop_front()));
            chk("tdi", 32'(TDI), 32'(exp_tdi.pop_front()));
            chk("trst", 32'(TRST), 32'(exp_trst.pop_front()));
        end
        loop_ff <= TDI;
        tck_n   <= tck_n + 1;
    end

    always @(negedge CLK) begin
        if (rst && bus.rsp_valid) begin
            chk("ready_during_rsp", 32'(bus.cmd_ready), 32'd0);
            if (bus.rsp_ready) begin
                if (exp_rsp.size() == 0) begin
                    n_chk++;
                    $display("FAIL rsp_extra: got %h expected none", bus.rsp_data);
                end else begin
                    chk("rsp_data", bus.rsp_data, exp_rsp.pop_front());
                end
            end
        end
    end

    always @(posedge CLK) begin
        #2;
        bus.rsp_ready = hold ? 1'b0 : 1'($urandom_range(0, 1));
    end

    function automatic bit trst_exp(input int i);
`ifdef JTAG_DRV_TRST_EN
        return i >= 2;
`else
        return (i >= 0);
`endif
    endfunction

    // Reference: list the TAP walk one TCK at a time from Run-Test/Idle
    task automatic model(input logic [1:0] op, input logic [4:0] len,
                         input logic [31:0] data, input bit loop,
                         output int ntck);
        int n = int'(len) + 1;
        int pn;
        logic [31:0] r;
        if (op == 2'd0) begin
            for (int i = 0; i < 6; i++) begin
                exp_tms.push_back(i < 5);
                exp_tdi.push_back(1'b0);
                exp_trst.push_back(trst_exp(i));
            end
            ntck = 6;
        end else if (op == 2'd3) begin
            for (int i = 0; i < n; i++) begin
                exp_tms.push_back(1'b0);
                exp_tdi.push_back(1'b0);
                exp_trst.push_back(1'b1);
            end
            ntck = n;
        end else begin
            bit pre_ir [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
            bit pre_dr [3] = '{1'b1, 1'b0, 1'b0};
            pn = (op == 2'd1) ? 4 : 3;
            for (int i = 0; i < pn; i++) begin
                exp_tms.push_back(op == 2'd1 ? pre_ir[i] : pre_dr[i]);
                exp_tdi.push_back(1'b0);
                exp_trst.push_back(1'b1);
            end
            r = '0;
            for (int i = 0; i < n; i++) begin
                exp_tms.push_back(i == n - 1);
                exp_tdi.push_back(data[i]);
                exp_trst.push_back(1'b1);
                if (loop) r[i] = (i == 0) ? 1'b0 : data[i-1];
                else      r[i] = tdo_bits[model_tck + pn + i];
            end
            exp_tms.push_back(1'b1);
            exp_tms.push_back(1'b0);
            for (int i = 0; i < 2; i++) begin
                exp_tdi.push_back(1'b0);
                exp_trst.push_back(1'b1);
            end
            exp_rsp.push_back(r);
            ntck = pn + n + 2;
        end
        model_tck += ntck;
    endtask

    task automatic issue(input logic [1:0] op, input logic [4:0] len,
                         input logic [31:0] data, input bit loop, input bit hld);
        int ntck;
        int cnt;
        logic [31:0] held;
        model(op, len, data, loop, ntck);
        hold = hld;
        @(negedge CLK);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_len   = len;
        bus.cmd_data  = data;
        cnt = 0;
        while (!bus.cmd_ready && cnt < 2000) begin
            @(negedge CLK);
            cnt++;
        end
        if (!bus.cmd_ready) begin
            n_chk++;
            $display("FAIL accept_timeout: cmd_ready never rose");
            $display("%0d/%0d checks passed", n_pass, n_chk);
            $fatal(1, "accept timeout");
        end
        loop_mode = loop;
        @(posedge CLK);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'($urandom);
        bus.cmd_len   = 5'($urandom);
        bus.cmd_data  = $urandom;
        chk("busy_after_accept", 32'(busy), 32'd1);
        cnt = 0;
        while (busy && cnt < 5000) begin
            @(posedge CLK);
            #1;
            cnt++;
        end
        chk("cmd_clks", 32'(cnt), 32'(ntck * 2 * DIV));
        chk("rsp_valid_after_post", 32'(bus.rsp_valid), 32'(op == 2'd1 || op == 2'd2));
        chk("ready_after_post", 32'(bus.cmd_ready), 32'(op == 2'd0 || op == 2'd3));
        if (hld) begin
            held = bus.rsp_data;
            repeat (20) begin
                @(negedge CLK);
                bus.cmd_valid = 1'b1;
                chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
                chk("hold_data", bus.rsp_data, held);
                chk("hold_ready", 32'(bus.cmd_ready), 32'd0);
                chk("hold_busy", 32'(busy), 32'd0);
            end
            @(negedge CLK);
            bus.cmd_valid = 1'b0;
            hold = 1'b0;
        end
    endtask

    initial begin
        int cnt;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_len   = '0;
        bus.cmd_data  = '0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 8192; i++) tdo_bits[i] = 1'($urandom);

        rst = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_tck", 32'(TCK), 32'd0);
        chk("rst_tms", 32'(TMS), 32'd1);
        chk("rst_tdi", 32'(TDI), 32'd0);
        chk("rst_trst", 32'(TRST), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_data", bus.rsp_data, 32'd0);
        chk("rst_ready", 32'(bus.cmd_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        @(posedge CLK);
        #1;
        chk("ready_after_rst", 32'(bus.cmd_ready), 32'd1);

        issue(2'd0, 5'd0, 32'h0, 1'b0, 1'b0);
        issue(2'd1, 5'd3, 32'hE, 1'b0, 1'b0);
        issue(2'd2, 5'd0, 32'h1, 1'b0, 1'b0);
        issue(2'd2, 5'd31, 32'hA5A5_5A5A, 1'b1, 1'b0);
        issue(2'd3, 5'd4, 32'h0, 1'b0, 1'b0);
        issue(2'd2, 5'd7, $urandom, 1'b0, 1'b1);
        for (int k = 0; k < 25; k++)
            issue(2'($urandom_range(0, 3)), 5'($urandom), $urandom,
                  1'($urandom_range(0, 3) == 0), 1'b0);

        cnt = 0;
        while ((exp_rsp.size() != 0 || !bus.cmd_ready) && cnt < 500) begin
            @(negedge CLK);
            cnt++;
        end
        chk("rsp_queue_drained", 32'(exp_rsp.size()), 32'd0);
        chk("tck_queue_drained", 32'(exp_tms.size()), 32'd0);
        chk("final_ready", 32'(bus.cmd_ready), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
